// File: rtl/cdb_scheduler_if.sv
// Request/grant bundle between the CDB scheduler and its requesters.
// Release pulses travel as release_bus since `release` is a reserved word.
interface cdb_scheduler_if #(
    parameter int CDB_COUNT = 2,
    parameter int REQ_COUNT = 4
);
    logic [REQ_COUNT-1:0]   req;
    logic [REQ_COUNT-1:0]   release_bus;
    logic [4*CDB_COUNT-1:0] select;
    logic [REQ_COUNT-1:0]   granted;
    logic [REQ_COUNT-1:0]   revoked;

    modport master (
        output req,
        output release_bus,
        input  select,
        input  granted,
        input  revoked
    );

    modport slave (
        input  req,
        input  release_bus,
        output select,
        output granted,
        output revoked
    );
endinterface

// File: rtl/cdb_scheduler.sv
// Round-robin owner allocation of the common data buses with level-held
// ownership, owner release and hold-time revocation when others starve.
module cdb_scheduler #(
    parameter int CDB_COUNT = 2,
    parameter int REQ_COUNT = 4,
    parameter int HOLD_MAX  = 8
) (
    input  logic            clk,
    input  logic            reset,
    cdb_scheduler_if.slave  bus
);
    localparam int unsigned NREQ  = REQ_COUNT;
    localparam int          RR_W  = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;
    localparam int          CNT_W = $clog2(HOLD_MAX + 1) + 1;
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

    typedef enum logic {BUS_FREE, BUS_OWNED} bus_state_t;

    bus_state_t           state    [CDB_COUNT];
    logic [3:0]           owner    [CDB_COUNT];
    logic [CNT_W-1:0]     hold_cnt [CDB_COUNT];
    logic [RR_W-1:0]      rr;
    logic [REQ_COUNT-1:0] granted_q;
    logic [REQ_COUNT-1:0] revoked_q;

    logic [REQ_COUNT-1:0] owner_oh [CDB_COUNT];
    logic [REQ_COUNT-1:0] eligible;
    logic                 any_eligible;
    logic [CDB_COUNT-1:0] rel_hit;
    logic [CDB_COUNT-1:0] rev_hit;
    logic [REQ_COUNT-1:0] freed_mask;
    logic [REQ_COUNT-1:0] revoked_mask;

    logic [REQ_COUNT-1:0] elig_rot;
    logic [CDB_COUNT-1:0] alloc_hit;
    logic [3:0]           alloc_addr [CDB_COUNT];
    logic [REQ_COUNT-1:0] grant_mask;
    logic [RR_W-1:0]      rr_next;
    int unsigned          idx;
    int unsigned          nxt;
    logic                 placed;

    // Owners are never eligible, so releasing/revoked units drop out implicitly.
    always_comb begin
        eligible     = bus.req & ~granted_q;
        any_eligible = |eligible;
        rel_hit      = '0;
        rev_hit      = '0;
        freed_mask   = '0;
        revoked_mask = '0;
        for (int unsigned k = 0; k < CDB_COUNT; k++) begin
            owner_oh[k] = '0;
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (owner[k] == 4'(i + 1)) owner_oh[k][i] = 1'b1;
            end
            if (state[k] == BUS_OWNED) begin
                rel_hit[k] = |(owner_oh[k] & bus.release_bus);
                rev_hit[k] = (HOLD_MAX != 0) && !rel_hit[k] &&
                             (hold_cnt[k] == HOLD_LIM) && any_eligible;
            end
            if (rel_hit[k] || rev_hit[k]) freed_mask   = freed_mask | owner_oh[k];
            if (rev_hit[k])               revoked_mask = revoked_mask | owner_oh[k];
        end
    end

    // elig_rot[j] is the eligibility of requester (rr + j) mod REQ_COUNT.
    always_comb begin
        elig_rot   = REQ_COUNT'({eligible, eligible} >> rr);
        alloc_hit  = '0;
        grant_mask = '0;
        rr_next    = rr;
        idx        = 0;
        nxt        = 0;
        placed     = 1'b0;
        for (int unsigned k = 0; k < CDB_COUNT; k++) alloc_addr[k] = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            idx = 32'(rr) + j;
            if (idx >= NREQ) idx = idx - NREQ;
            placed = 1'b0;
            if (elig_rot[j]) begin
                for (int unsigned k = 0; k < CDB_COUNT; k++) begin
                    if (!placed && state[k] == BUS_FREE && !alloc_hit[k]) begin
                        alloc_hit[k]  = 1'b1;
                        alloc_addr[k] = 4'(idx + 1);
                        placed        = 1'b1;
                    end
                end
            end
            if (placed) begin
                for (int unsigned i = 0; i < NREQ; i++) begin
                    if (i == idx) grant_mask[i] = 1'b1;
                end
                nxt     = (idx + 1 == NREQ) ? 0 : idx + 1;
                rr_next = RR_W'(nxt);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr        <= '0;
            granted_q <= '0;
            revoked_q <= '0;
            for (int unsigned k = 0; k < CDB_COUNT; k++) begin
                state[k]    <= BUS_FREE;
                owner[k]    <= '0;
                hold_cnt[k] <= '0;
            end
        end else begin
            rr        <= rr_next;
            granted_q <= (granted_q & ~freed_mask) | grant_mask;
            revoked_q <= revoked_mask;
            for (int unsigned k = 0; k < CDB_COUNT; k++) begin
                if (rel_hit[k] || rev_hit[k]) begin
                    state[k]    <= BUS_FREE;
                    owner[k]    <= '0;
                    hold_cnt[k] <= '0;
                end else if (alloc_hit[k]) begin
                    state[k]    <= BUS_OWNED;
                    owner[k]    <= alloc_addr[k];
                    hold_cnt[k] <= CNT_W'(1);
                end else if (state[k] == BUS_OWNED && HOLD_MAX != 0 &&
                             hold_cnt[k] != HOLD_LIM) begin
                    hold_cnt[k] <= hold_cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        bus.select = '0;
        for (int unsigned k = 0; k < CDB_COUNT; k++) bus.select[4*k +: 4] = owner[k];
    end

    assign bus.granted = granted_q;
    assign bus.revoked = revoked_q;
endmodule

// File: tb/tb_cdb_scheduler.sv
// Bench for cdb_scheduler: three instances (HOLD_MAX 8/4/0) checked every cycle
// against a queue-based allocation model, plus literal checks of key scenarios.
module tb_cdb_scheduler;
    localparam int NI = 3;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] req_v [NI];
    logic [3:0] rel_v [NI];
    logic [7:0] sel_o [NI];
    logic [3:0] gnt_o [NI];
    logic [3:0] rev_o [NI];

    int n_cmp  = 0;
    int n_bad  = 0;
    bit cmp_en = 1'b0;

    int         m_own  [NI][2];
    int         m_hold [NI][2];
    int         m_rr   [NI];
    logic [3:0] m_rev  [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int HM = (g == 0) ? 8 : ((g == 1) ? 4 : 0);
        cdb_scheduler_if #(.CDB_COUNT(2), .REQ_COUNT(4)) ifc ();
        assign ifc.req         = req_v[g];
        assign ifc.release_bus = rel_v[g];
        assign sel_o[g]        = ifc.select;
        assign gnt_o[g]        = ifc.granted;
        assign rev_o[g]        = ifc.revoked;
        cdb_scheduler #(.CDB_COUNT(2), .REQ_COUNT(4), .HOLD_MAX(HM)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (ifc)
        );
    end

    function automatic int hm(int n);
        return (n == 0) ? 8 : ((n == 1) ? 4 : 0);
    endfunction

    function automatic logic [7:0] m_sel(int n);
        logic [3:0] lo, hi;
        lo = 4'(m_own[n][0]);
        hi = 4'(m_own[n][1]);
        return {hi, lo};
    endfunction

    function automatic logic [3:0] m_gnt(int n);
        logic [3:0] g;
        g = '0;
        for (int k = 0; k < 2; k++) if (m_own[n][k] != 0) g[m_own[n][k] - 1] = 1'b1;
        return g;
    endfunction

    task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 8'h%h, expected 8'h%h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of the allocation rules for instance n.
    task automatic model_step(int n);
        int elig[$];
        int free_bus[$];
        bit owns[4];
        int i, k, h;
        h = hm(n);
        for (int r = 0; r < 4; r++) owns[r] = 1'b0;
        for (int b = 0; b < 2; b++) if (m_own[n][b] != 0) owns[m_own[n][b] - 1] = 1'b1;
        for (int j = 0; j < 4; j++) begin
            i = (m_rr[n] + j) % 4;
            if (req_v[n][i] && !owns[i]) elig.push_back(i);
        end
        m_rev[n] = '0;
        for (int b = 0; b < 2; b++) begin
            if (m_own[n][b] == 0) begin
                free_bus.push_back(b);
            end else if (rel_v[n][m_own[n][b] - 1]) begin
                m_own[n][b]  = 0;
                m_hold[n][b] = 0;
            end else if (h != 0 && m_hold[n][b] == h && elig.size() > 0) begin
                m_rev[n][m_own[n][b] - 1] = 1'b1;
                m_own[n][b]  = 0;
                m_hold[n][b] = 0;
            end else if (m_hold[n][b] < h) begin
                m_hold[n][b]++;
            end
        end
        while (free_bus.size() > 0 && elig.size() > 0) begin
            k = free_bus.pop_front();
            i = elig.pop_front();
            m_own[n][k]  = i + 1;
            m_hold[n][k] = 1;
            m_rr[n]      = (i + 1) % 4;
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < NI; n++) begin
                m_rr[n]  = 0;
                m_rev[n] = '0;
                for (int b = 0; b < 2; b++) begin
                    m_own[n][b]  = 0;
                    m_hold[n][b] = 0;
                end
            end
        end else begin
            for (int n = 0; n < NI; n++) model_step(n);
        end
    end

    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            for (int n = 0; n < NI; n++) begin
                chk($sformatf("sel%0d", n), sel_o[n], m_sel(n));
                chk($sformatf("gnt%0d", n), gnt_o[n], m_gnt(n));
                chk($sformatf("rev%0d", n), rev_o[n], m_rev[n]);
            end
        end
    end

    task automatic set_all(logic [3:0] r, logic [3:0] l);
        for (int n = 0; n < NI; n++) begin
            req_v[n] = r;
            rel_v[n] = l;
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        set_all(4'b0000, 4'b0000);
        @(negedge clk);
        #2 reset = 1'b0;
        cmp_en = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_all(4'b0000, 4'b0000);

        // single requester grant and release
        do_reset();
        set_all(4'b0001, 4'b0000);
        step();
        chk("t2_sel", sel_o[0], 8'h01);
        chk("t2_gnt", gnt_o[0], 4'b0001);
        chk("t2_sel_m", m_sel(0), 8'h01);
        set_all(4'b0000, 4'b0000);
        step();
        set_all(4'b0000, 4'b0001);
        step();
        chk("t2_rel_sel", sel_o[0], 8'h00);
        chk("t2_rel_gnt", gnt_o[0], 4'b0000);
        set_all(4'b0000, 4'b0000);

        // all request; round-robin resumes from rr=2 after releases
        do_reset();
        set_all(4'b1111, 4'b0000);
        step();
        chk("t3_sel", sel_o[0], 8'h21);
        chk("t3_gnt", gnt_o[0], 4'b0011);
        step();
        set_all(4'b1111, 4'b0011);
        step();
        chk("t3_rel_sel", sel_o[0], 8'h00);
        set_all(4'b1111, 4'b0000);
        step();
        chk("t3_rr_sel", sel_o[0], 8'h43);
        chk("t3_rr_gnt", gnt_o[0], 4'b1100);
        chk("t3_rr_sel_m", m_sel(0), 8'h43);

        // asynchronous reset while owned, then grant from rr=0
        #2 reset = 1'b1;
        #1;
        chk("t1_sel", sel_o[0], 8'h00);
        chk("t1_gnt", gnt_o[0], 4'b0000);
        chk("t1_rev", rev_o[0], 4'b0000);
        chk("t1_sel_h4", sel_o[1], 8'h00);
        @(negedge clk);
        #2 reset = 1'b0;
        step();
        chk("t1_regrant_sel", sel_o[0], 8'h21);
        chk("t1_regrant_gnt", gnt_o[0], 4'b0011);

        // hold-time revocation with HOLD_MAX=4 (instance 1)
        do_reset();
        set_all(4'b0111, 4'b0000);
        step();
        chk("t4_sel", sel_o[1], 8'h21);
        step();
        step();
        step();
        chk("t4_norev", rev_o[1], 4'b0000);
        step();
        chk("t4_rev", rev_o[1], 4'b0011);
        chk("t4_rev_sel", sel_o[1], 8'h00);
        chk("t4_rev_gnt", gnt_o[1], 4'b0000);
        chk("t4_rev_m", m_rev[1], 4'b0011);
        step();
        chk("t4_sel2", sel_o[1], 8'h13);
        chk("t4_gnt2", gnt_o[1], 4'b0101);
        chk("t4_rev_end", rev_o[1], 4'b0000);
        chk("t4_sel2_m", m_sel(1), 8'h13);

        // owner req+release together; non-owner release ignored
        do_reset();
        set_all(4'b0001, 4'b0000);
        step();
        chk("t5_gnt", gnt_o[0], 4'b0001);
        set_all(4'b0001, 4'b0101);
        step();
        chk("t5_rel_sel", sel_o[0], 8'h00);
        chk("t5_rel_gnt", gnt_o[0], 4'b0000);
        set_all(4'b0001, 4'b0000);
        step();
        chk("t5_regrant_sel", sel_o[0], 8'h01);
        chk("t5_regrant_gnt", gnt_o[0], 4'b0001);

        // HOLD_MAX=0 never revokes (instance 2)
        do_reset();
        set_all(4'b0111, 4'b0000);
        step();
        for (int c = 0; c < 50; c++) begin
            step();
            chk("t6_rev", rev_o[2], 4'b0000);
            chk("t6_sel", sel_o[2], 8'h21);
        end

        // randomized traffic, per-instance requester behaviour
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (cyc % 1000 == 999) begin
                #2 reset = 1'b1;
                @(negedge clk);
                #2 reset = 1'b0;
            end
            for (int n = 0; n < NI; n++) begin
                logic [3:0] g;
                g = m_gnt(n);
                for (int i = 0; i < 4; i++) begin
                    if (g[i]) begin
                        req_v[n][i] = ($urandom_range(0, 3) == 0);
                        rel_v[n][i] = ($urandom_range(0, 5) == 0);
                    end else begin
                        if (!req_v[n][i]) req_v[n][i] = ($urandom_range(0, 2) == 0);
                        rel_v[n][i] = !req_v[n][i] && ($urandom_range(0, 15) == 0);
                    end
                end
            end
        end
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cdb_scheduler.md
# cdb_scheduler

Allocates the common data buses (CDBs) among the result-producing units (requesters) of the out-of-order core. It drives the packed 4-bit-per-bus `select` vector that every per-unit CDB arbiter decodes, so the scheduler is the single place where bus ownership is decided. Ownership is level-held until the owner releases the bus. Requesters are served round-robin, and a hold-time limit revokes long-held buses when another unit is starving.

## Interface
- `CDB_COUNT`, 2, number of common data buses.
- `REQ_COUNT`, 4, number of requesters; legal range 1..15. Requester i has device address i+1; address 0 means the bus is disconnected.
- `HOLD_MAX`, 8, maximum cycles a requester may own a bus while others wait. 0 disables revocation.

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  REQ_COUNT  request a bus; held high until `granted[i]` is seen.
- `release`  in  REQ_COUNT  one-cycle pulse from an owner to free its bus.
- `select`  out  4*CDB_COUNT  slot k (bits 4k+3:4k) holds the owner address of CDB k, or 0 if the bus is free; registered.
- `granted`  out  REQ_COUNT  level, high while requester i owns a bus; registered.
- `revoked`  out  REQ_COUNT  one-cycle pulse when a bus is taken from requester i by timeout; registered.

## Operation
- Each CDB k has two states, FREE and OWNED. It also has a 4-bit owner register and a hold counter that saturates at HOLD_MAX.
- Eligible requester: `req[i]`=1, not currently owning a bus, and not releasing or revoked this cycle.
- Allocation each cycle:
  - Scan requesters starting at pointer `rr` and wrap modulo REQ_COUNT.
  - Assign eligible requesters, in scan order, to FREE buses in ascending index order.
  - A requester receives at most one bus.
- `rr` update:
  - If any grant was made, `rr` becomes (index of the last requester granted in scan order + 1) mod REQ_COUNT.
  - Otherwise `rr` is unchanged.
- Grant: the bus goes to OWNED, the owner register is set to i+1, the hold counter is set to 1, and `granted[i]` is set.
- Release: `release[i]` by the current owner returns that bus to FREE. The owner register is cleared to 0 and `granted[i]` is cleared.
  - `release` from a non-owner is ignored.
- Revoke: applies when HOLD_MAX≠0, an OWNED bus's counter equals HOLD_MAX, and at least one eligible requester exists.
  - The bus returns to FREE, `granted` is cleared, and `revoked[owner]` pulses.
  - All buses meeting the condition in the same cycle are revoked together.
- A bus freed by release or revoke in cycle t is not reallocated in cycle t. It becomes assignable at the next edge.
- When the owner asserts `req` and `release` in the same cycle, release wins. The requester is re-considered next cycle if `req` is still high.
- `req` from a current owner has no effect.
- Reset (asynchronous, at any time): `select`=0, `granted`=0, `revoked`=0, `rr`=0, all buses FREE, all counters 0. In-flight ownership is discarded.

## Timing
- Request-to-grant latency:
  - `req` is sampled at edge n.
  - If a bus is FREE, `granted` and the `select` slot are valid after edge n.
  - So the first transfer cycle is n+1.
- Release latency:
  - `release` is sampled at edge n, and the `select` slot reads 0 after edge n.
  - The earliest reallocation of that bus is at edge n+1.
- Hold counter: increments every edge while OWNED and saturates at HOLD_MAX. At grant it is 1 after the grant edge.
- `revoked` is high for exactly one cycle. It coincides with `granted` going low.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
All scenarios use CDB_COUNT=2 and REQ_COUNT=4 unless stated.

1. Reset, then assert and deassert `reset` mid-cycle while buses are owned. Required: `select`=8'h00, `granted`=4'b0000 and `revoked`=0 immediately after the reset assertion. The next request is granted from `rr`=0.
2. `req`=4'b0001 sampled at edge 1. Required: `select`=8'h01 and `granted`=4'b0001 after edge 1. A `release[0]` pulse at edge 3 gives `select`=8'h00 after edge 3.
3. `req`=4'b1111 from reset, with no releases. Required: `select`=8'h21 and `granted`=4'b0011 after edge 1, with `rr`=2. Releasing 0 and 1 at edge 3 gives `select`=8'h00 after edge 3, then `select`=8'h43 and `granted`=4'b1100 after edge 4.
4. HOLD_MAX=4, `req`=4'b0111 held, no releases. Required:
   - `select`=8'h21 after edge 1.
   - `revoked`=4'b0011 pulse and `select`=8'h00 after edge 5.
   - `select`=8'h13, `granted`=4'b0101 and `rr`=1 after edge 6.
5. Owner 0 on CDB 0 asserts `req[0]` and `release[0]` together at edge n, while `release[2]` pulses from a non-owner. Required: slot 0 reads 0 after edge n, and requester 0 is re-granted after edge n+1. The pulse from requester 2 causes no change.
6. HOLD_MAX=0, one owner held for 50 cycles with another requester waiting and both buses busy. Required: no `revoked` pulse and `select` stable throughout.
